// File: rtl/axis_fifo_pkg.sv
// Shared defaults and width helper for the AXI4-Stream synchronous FIFO.
package axis_fifo_pkg;

   localparam int DEFAULT_DATA_W = 64;
   localparam int DEFAULT_DEPTH  = 512;

   // Pointers and the occupancy count need one bit beyond the address so that
   // a completely full FIFO (DEPTH entries) can be represented.
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module axis_fifo_ram
   import axis_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The read port is combinational so the head entry falls straight through.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO with occupancy count.
// Define AXIS_FIFO_DATA_COUNT_EN to implement axis_data_count; otherwise it reads 0.
module axis_sync_fifo
   import axis_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   localparam int CNT_W = calc_cnt_w(DEPTH)
)(
   input  logic              s_aclk,
   input  logic              s_aresetn,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [CNT_W-1:0]  axis_data_count
);

   localparam int ADDR_W = CNT_W - 1;
   localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

   logic [CNT_W-1:0] wr_ptr;
   logic [CNT_W-1:0] rd_ptr;
   logic             ready_en;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Wrap bits distinguish full from empty when the address bits coincide.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   assign s_axis_tready = ready_en & ~full;
   assign m_axis_tvalid = ~empty;

   assign push = s_axis_tvalid & s_axis_tready;
   assign pop  = m_axis_tvalid & m_axis_tready;

   // Holds tready low through reset and for the first edge after release.
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   axis_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (s_aclk),
      .wr_en   (push),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (s_axis_tdata),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (m_axis_tdata)
   );

`ifdef AXIS_FIFO_DATA_COUNT_EN
   logic [CNT_W-1:0] count_q;

   // Kept separately from the pointers so the downstream burst gate sees a clean register.
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         count_q <= '0;
      end else begin
         if (push && !pop) begin
            count_q <= count_q + PTR_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - PTR_ONE;
         end
      end
   end

   assign axis_data_count = count_q;
`else
   assign axis_data_count = '0;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo: reset, single word, fill, full+pop, drain, streaming, mid-run reset.
module tb_axis_sync_fifo;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 512;
   localparam int CNT_W  = 10;

   logic              clk = 1'b0;
   logic              s_aresetn;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic [CNT_W-1:0]  axis_data_count;

   logic [DATA_W-1:0] sb[$];
   int tests_run    = 0;
   int tests_failed = 0;

   axis_sync_fifo dut (
      .s_aclk          (clk),
      .s_aresetn       (s_aresetn),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tdata    (s_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .axis_data_count (axis_data_count)
   );

   always #5 clk = ~clk;

   // The count port only carries occupancy when the optional counter is built.
   function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef AXIS_FIFO_DATA_COUNT_EN
      return CNT_W'(n);
`else
      return CNT_W'(n * 0);
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      s_aresetn     = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'h1111_2222_3333_4444;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         tests_run++;
         if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || axis_data_count !== exp_cnt(0)) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: tvalid=%b tready=%b count=%0d, expected 0 0 0",
                     m_axis_tvalid, s_axis_tready, axis_data_count);
         end
      end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      s_aresetn     = 1'b1;
      #1;
      tests_run++;
      if (s_axis_tready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_early: tready=%b, expected 0", s_axis_tready);
      end
      cyc();
      tests_run++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release: tready=%b tvalid=%b, expected 1 0",
                  s_axis_tready, m_axis_tvalid);
      end
   endtask

   task automatic test_single_word();
      logic [DATA_W-1:0] exp;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hDEAD_BEEF_0000_0001;
      sb.push_back(s_axis_tdata);
      cyc();
      s_axis_tvalid = 1'b0;
      exp = sb.pop_front();
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp || axis_data_count !== exp_cnt(1)) begin
         tests_failed++;
         $display("[TB] FAIL single_word: tvalid=%b data=%h count=%0d, expected 1 %h %0d",
                  m_axis_tvalid, m_axis_tdata, axis_data_count, exp, exp_cnt(1));
      end
      m_axis_tready = 1'b1;
      cyc();
      m_axis_tready = 1'b0;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || axis_data_count !== exp_cnt(0)) begin
         tests_failed++;
         $display("[TB] FAIL single_pop: tvalid=%b count=%0d, expected 0 %0d",
                  m_axis_tvalid, axis_data_count, exp_cnt(0));
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         tests_run++;
         if (s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fill_ready[%0d]: tready=%b, expected 1", i, s_axis_tready);
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 64'(i);
         sb.push_back(s_axis_tdata);
         cyc();
      end
      // 513th word offered while full must be refused.
      s_axis_tdata = 64'hBAD0_BAD0_BAD0_BAD0;
      tests_run++;
      if (s_axis_tready !== 1'b0 || axis_data_count !== exp_cnt(DEPTH) || m_axis_tvalid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL fill_full: tready=%b count=%0d tvalid=%b, expected 0 %0d 1",
                  s_axis_tready, axis_data_count, m_axis_tvalid, exp_cnt(DEPTH));
      end
      cyc();
      s_axis_tvalid = 1'b0;
      tests_run++;
      if (s_axis_tready !== 1'b0 || axis_data_count !== exp_cnt(DEPTH)) begin
         tests_failed++;
         $display("[TB] FAIL fill_overflow: tready=%b count=%0d, expected 0 %0d",
                  s_axis_tready, axis_data_count, exp_cnt(DEPTH));
      end
   endtask

   task automatic test_full_pop();
      logic [DATA_W-1:0] exp;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hBAD1_BAD1_BAD1_BAD1;
      m_axis_tready = 1'b1;
      exp = sb.pop_front();
      tests_run++;
      if (m_axis_tdata !== exp) begin
         tests_failed++;
         $display("[TB] FAIL full_pop_data: data=%h, expected %h", m_axis_tdata, exp);
      end
      cyc();
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      tests_run++;
      if (s_axis_tready !== 1'b1 || axis_data_count !== exp_cnt(DEPTH - 1) || m_axis_tvalid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL full_pop: tready=%b count=%0d tvalid=%b, expected 1 %0d 1",
                  s_axis_tready, axis_data_count, m_axis_tvalid, exp_cnt(DEPTH - 1));
      end
   endtask

   task automatic test_drain();
      logic [DATA_W-1:0] exp;
      m_axis_tready = 1'b1;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         tests_run++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
            tests_failed++;
            $display("[TB] FAIL drain: tvalid=%b data=%h, expected 1 %h",
                     m_axis_tvalid, m_axis_tdata, exp);
         end
         cyc();
      end
      m_axis_tready = 1'b0;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || axis_data_count !== exp_cnt(0)) begin
         tests_failed++;
         $display("[TB] FAIL drain_empty: tvalid=%b count=%0d, expected 0 %0d",
                  m_axis_tvalid, axis_data_count, exp_cnt(0));
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] exp;
      for (int i = 0; i < 16; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = {32'hA5A5_0000, 32'(i)};
         sb.push_back(s_axis_tdata);
         cyc();
      end
      m_axis_tready = 1'b1;
      for (int i = 16; i < 1016; i++) begin
         s_axis_tdata = {32'hA5A5_0000, 32'(i)};
         exp = sb.pop_front();
         tests_run++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp || axis_data_count !== exp_cnt(16) ||
             s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stream[%0d]: tvalid=%b data=%h count=%0d tready=%b, expected 1 %h %0d 1",
                     i, m_axis_tvalid, m_axis_tdata, axis_data_count, s_axis_tready, exp, exp_cnt(16));
         end
         sb.push_back(s_axis_tdata);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      tests_run++;
      if (axis_data_count !== exp_cnt(16)) begin
         tests_failed++;
         $display("[TB] FAIL stream_count: count=%0d, expected %0d", axis_data_count, exp_cnt(16));
      end
   endtask

   task automatic test_mid_reset();
      logic [DATA_W-1:0] exp;
      for (int i = 0; i < 84; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = {32'h5A5A_0000, 32'(i)};
         sb.push_back(s_axis_tdata);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      tests_run++;
      if (axis_data_count !== exp_cnt(100) || m_axis_tvalid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_preload: count=%0d tvalid=%b, expected %0d 1",
                  axis_data_count, m_axis_tvalid, exp_cnt(100));
      end
      s_aresetn = 1'b0;
      #2;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || axis_data_count !== exp_cnt(0)) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_async: tvalid=%b tready=%b count=%0d, expected 0 0 0",
                  m_axis_tvalid, s_axis_tready, axis_data_count);
      end
      sb.delete();
      cyc();
      s_aresetn = 1'b1;
      cyc();
      tests_run++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_release: tready=%b tvalid=%b, expected 1 0",
                  s_axis_tready, m_axis_tvalid);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hCAFE_F00D_1234_5678;
      sb.push_back(s_axis_tdata);
      cyc();
      s_axis_tvalid = 1'b0;
      exp = sb.pop_front();
      tests_run++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp || axis_data_count !== exp_cnt(1)) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_first: tvalid=%b data=%h count=%0d, expected 1 %h %0d",
                  m_axis_tvalid, m_axis_tdata, axis_data_count, exp, exp_cnt(1));
      end
      m_axis_tready = 1'b1;
      cyc();
      m_axis_tready = 1'b0;
      tests_run++;
      if (m_axis_tvalid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset_empty: tvalid=%b, expected 0", m_axis_tvalid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_word();
      test_fill();
      test_full_pop();
      test_drain();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
